scv_cegen: RTL and testbench



---
 rtl/scv_pkg.sv | 22 ++
 rtl/scv_cegen_ch.sv | 62 ++++++
 rtl/scv_cegen.sv | 49 ++++
 tb/tb_scv_cegen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/scv_pkg.sv
// scv_pkg: shared SCV constants, clock-enable channel map and default ratios
package scv_pkg;

    localparam int CEGEN_CH_CPU = 0;
    localparam int CEGEN_CH_APU = 1;
    localparam int CEGEN_CH_VDC = 2;

    localparam int CEGEN_ACC_W = 9;

    localparam int CEGEN_MUL0 = 88;
    localparam int CEGEN_DIV0 = 315;
    localparam int CEGEN_MUL1 = 22;
    localparam int CEGEN_DIV1 = 105;
    localparam int CEGEN_MUL2 = 1;
    localparam int CEGEN_DIV2 = 7;

    typedef struct packed {
        logic [CEGEN_ACC_W-1:0] mul;
        logic [CEGEN_ACC_W-1:0] div;
    } cegen_ratio_t;

endpackage

// File: rtl/scv_cegen_ch.sv
// scv_cegen_ch: one fractional clock-enable channel (mul/div accumulator plus phase counter)
module scv_cegen_ch
    import scv_pkg::*;
#(
    parameter int ACC_W   = CEGEN_ACC_W,
    parameter int PH_W    = 2,
    parameter int MUL_RST = 1,
    parameter int DIV_RST = 1
) (
    input  logic             CLK,
    input  logic             RESB,
    input  logic             RUN,
    input  logic             SYNC,
    input  logic             CFG_WE,
    input  logic [ACC_W-1:0] CFG_MUL,
    input  logic [ACC_W-1:0] CFG_DIV,
    output logic             CE,
    output logic [PH_W-1:0]  PHASE,
    output logic             PH_WRAP
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] mul;
    logic [ACC_W-1:0] div;
    logic [ACC_W-1:0] rem;
    logic [PH_W-1:0]  ph;
    logic [ACC_W:0]   nxt;
    logic             fire;

    // Accumulate at one extra bit so acc+mul never overflows; the remainder fits ACC_W bits.
    always_comb begin
        nxt     = {1'b0, acc} + {1'b0, mul};
        fire    = nxt >= {1'b0, div};
        rem     = nxt[ACC_W-1:0] - div;
        CE      = fire & RUN & RESB & ~SYNC & ~CFG_WE;
        PH_WRAP = CE & (ph == '1);
        PHASE   = ph;
    end

    // Ratio writes land even under SYNC; SYNC or a write restarts the sequence.
    always_ff @(posedge CLK) begin
        if (!RESB) begin
            acc <= '0;
            ph  <= '0;
            mul <= ACC_W'(MUL_RST);
            div <= ACC_W'(DIV_RST);
        end else begin
            if (CFG_WE) begin
                mul <= CFG_MUL;
                div <= CFG_DIV;
            end
            if (SYNC || CFG_WE) begin
                acc <= '0;
                ph  <= '0;
            end else if (RUN) begin
                acc <= (mul >= div) ? '0 : fire ? rem : nxt[ACC_W-1:0];
                if (fire) ph <= ph + 1'b1;
            end
        end
    end

endmodule

// File: rtl/scv_cegen.sv
// scv_cegen: multi-channel fractional clock-enable generator feeding CPU, APU and VDC
module scv_cegen
    import scv_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int ACC_W = CEGEN_ACC_W,
    parameter int PH_W  = 2,
    parameter int MUL0  = CEGEN_MUL0,
    parameter int DIV0  = CEGEN_DIV0,
    parameter int MUL1  = CEGEN_MUL1,
    parameter int DIV1  = CEGEN_DIV1,
    parameter int MUL2  = CEGEN_MUL2,
    parameter int DIV2  = CEGEN_DIV2,
    parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                CLK,
    input  logic                RESB,
    input  logic [NCH-1:0]      RUN,
    input  logic                SYNC,
    input  logic                CFG_WE,
    input  logic [CH_W-1:0]     CFG_CH,
    input  logic [ACC_W-1:0]    CFG_MUL,
    input  logic [ACC_W-1:0]    CFG_DIV,
    output logic [NCH-1:0]      CE,
    output logic [NCH*PH_W-1:0] PHASE,
    output logic [NCH-1:0]      PH_WRAP
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        scv_cegen_ch #(
            .ACC_W  (ACC_W),
            .PH_W   (PH_W),
            .MUL_RST((g == 0) ? MUL0 : (g == 1) ? MUL1 : MUL2),
            .DIV_RST((g == 0) ? DIV0 : (g == 1) ? DIV1 : DIV2)
        ) u_ch (
            .CLK    (CLK),
            .RESB   (RESB),
            .RUN    (RUN[g]),
            .SYNC   (SYNC),
            .CFG_WE (CFG_WE && (CFG_CH == CH_W'(g))),
            .CFG_MUL(CFG_MUL),
            .CFG_DIV(CFG_DIV),
            .CE     (CE[g]),
            .PHASE  (PHASE[g*PH_W +: PH_W]),
            .PH_WRAP(PH_WRAP[g])
        );
    end

endmodule

// File: tb/tb_scv_cegen.sv
// tb_scv_cegen: directed self-checking bench for scv_cegen
module tb_scv_cegen;

    logic       CLK;
    logic       RESB;
    logic [2:0] RUN;
    logic       SYNC;
    logic       CFG_WE;
    logic [1:0] CFG_CH;
    logic [8:0] CFG_MUL;
    logic [8:0] CFG_DIV;
    logic [2:0] CE;
    logic [5:0] PHASE;
    logic [2:0] PH_WRAP;

    logic [2:0] ce_s;
    logic [5:0] ph_s;
    logic [2:0] wr_s;
    int total = 0;
    int bad = 0;

    scv_cegen dut (
        .CLK(CLK), .RESB(RESB), .RUN(RUN), .SYNC(SYNC),
        .CFG_WE(CFG_WE), .CFG_CH(CFG_CH), .CFG_MUL(CFG_MUL), .CFG_DIV(CFG_DIV),
        .CE(CE), .PHASE(PHASE), .PH_WRAP(PH_WRAP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // sample mid-cycle, then move to just after the next rising edge
    task automatic adv;
        @(negedge CLK);
        ce_s = CE;
        ph_s = PHASE;
        wr_s = PH_WRAP;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RESB = 1'b0; RUN = 3'b111; SYNC = 1'b0; CFG_WE = 1'b0;
        CFG_CH = 2'd0; CFG_MUL = 9'd0; CFG_DIV = 9'd0;
        adv;
        adv;
        RESB = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        RESB = 1'b0;
        adv;
        total += 3;
        if (ce_s !== 3'b000) begin bad++; $display("FAIL reset_ce got=%b exp=000", ce_s); end
        if (wr_s !== 3'b000) begin bad++; $display("FAIL reset_wrap got=%b exp=000", wr_s); end
        if (ph_s !== 6'd0) begin bad++; $display("FAIL reset_phase got=%h exp=0", ph_s); end
        RESB = 1'b1;
        adv;
        total++;
        if (ce_s !== 3'b000) begin bad++; $display("FAIL release_k0_ce got=%b exp=000", ce_s); end
    endtask

    task automatic test_rates;
        int n0, n1, n2, nw, first2, stray;
        logic [1:0] eph;
        n0 = 0; n1 = 0; n2 = 0; nw = 0; first2 = -1; stray = 0; eph = 2'd0;
        do_reset;
        for (int k = 0; k < 1260; k++) begin
            adv;
            if (ce_s[0]) begin
                n0++;
                total++;
                if (ph_s[1:0] !== eph || wr_s[0] !== (eph == 2'd3)) begin
                    bad++;
                    $display("FAIL ch0_phase k=%0d got ph=%0d wrap=%b exp ph=%0d", k, ph_s[1:0], wr_s[0], eph);
                end
                eph = eph + 2'd1;
            end
            if (ce_s[1]) n1++;
            if (ce_s[2]) begin
                n2++;
                if (first2 < 0) first2 = k;
            end
            if (wr_s[0]) nw++;
            if ((wr_s & ~ce_s) != 3'b000) stray++;
        end
        total += 6;
        if (n0 != 352) begin bad++; $display("FAIL ch0_count got=%0d exp=352", n0); end
        if (n1 != 264) begin bad++; $display("FAIL ch1_count got=%0d exp=264", n1); end
        if (n2 != 180) begin bad++; $display("FAIL ch2_count got=%0d exp=180", n2); end
        if (first2 != 6) begin bad++; $display("FAIL ch2_first got=%0d exp=6", first2); end
        if (nw != 88) begin bad++; $display("FAIL ch0_wraps got=%0d exp=88", nw); end
        if (stray != 0) begin bad++; $display("FAIL wrap_without_ce got=%0d exp=0", stray); end
    endtask

    task automatic test_run_gap;
        int gapce, nextk;
        gapce = 0; nextk = -1;
        do_reset;
        for (int k = 0; k < 20; k++) begin
            RUN = (k >= 3 && k <= 12) ? 3'b011 : 3'b111;
            adv;
            if (k >= 3 && k <= 12 && ce_s[2]) gapce++;
            if (k > 12 && ce_s[2] && nextk < 0) nextk = k;
        end
        RUN = 3'b111;
        total += 2;
        if (gapce != 0) begin bad++; $display("FAIL gap_ce got=%0d exp=0", gapce); end
        if (nextk != 16) begin bad++; $display("FAIL gap_next got=%0d exp=16", nextk); end
    endtask

    task automatic test_cfg;
        logic e;
        logic [1:0] ep;
        do_reset;
        CFG_CH = 2'd1; CFG_MUL = 9'd1; CFG_DIV = 9'd2;
        for (int k = 0; k <= 20; k++) begin
            CFG_WE = (k == 9);
            adv;
            if (k == 9) begin
                total += 2;
                if (ce_s[1] !== 1'b0) begin bad++; $display("FAIL cfg_write_ce got=%b exp=0", ce_s[1]); end
                if (ph_s[3:2] !== 2'd1) begin bad++; $display("FAIL cfg_pre_phase got=%0d exp=1", ph_s[3:2]); end
            end else if (k > 9) begin
                e = ((k - 9) % 2 == 0);
                total++;
                if (ce_s[1] !== e) begin bad++; $display("FAIL cfg_ce k=%0d got=%b exp=%b", k, ce_s[1], e); end
                if (e) begin
                    ep = 2'(((k - 11) / 2) % 4);
                    total++;
                    if (ph_s[3:2] !== ep || wr_s[1] !== (ep == 2'd3)) begin
                        bad++;
                        $display("FAIL cfg_phase k=%0d got ph=%0d wrap=%b exp ph=%0d", k, ph_s[3:2], wr_s[1], ep);
                    end
                end
            end
        end
        CFG_WE = 1'b0;
    endtask

    task automatic test_degenerate;
        int cnt;
        do_reset;
        CFG_WE = 1'b1; CFG_CH = 2'd0; CFG_MUL = 9'd5; CFG_DIV = 9'd5;
        adv;
        CFG_WE = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            adv;
            if (ce_s[0]) cnt++;
        end
        total++;
        if (cnt != 20) begin bad++; $display("FAIL equal_ratio_ce got=%0d exp=20", cnt); end
        CFG_WE = 1'b1; CFG_CH = 2'd0; CFG_MUL = 9'd0; CFG_DIV = 9'd5;
        adv;
        CFG_WE = 1'b0;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            CFG_WE = (i == 500); CFG_CH = 2'd3; CFG_MUL = 9'd1; CFG_DIV = 9'd1;
            adv;
            if (ce_s[0]) cnt++;
        end
        CFG_WE = 1'b0;
        total++;
        if (cnt != 0) begin bad++; $display("FAIL zero_mul_ce got=%0d exp=0", cnt); end
    endtask

    task automatic test_sync_reset;
        int f0, f2;
        do_reset;
        for (int k = 0; k < 10; k++) adv;
        SYNC = 1'b1; CFG_WE = 1'b1; CFG_CH = 2'd2; CFG_MUL = 9'd1; CFG_DIV = 9'd2;
        adv;
        SYNC = 1'b0; CFG_WE = 1'b0;
        total++;
        if (ce_s !== 3'b000) begin bad++; $display("FAIL sync_ce got=%b exp=000", ce_s); end
        adv;
        total += 2;
        if (ce_s !== 3'b000) begin bad++; $display("FAIL sync_t1_ce got=%b exp=000", ce_s); end
        if (ph_s[1:0] !== 2'd0) begin bad++; $display("FAIL sync_phase got=%0d exp=0", ph_s[1:0]); end
        adv;
        total++;
        if (ce_s !== 3'b100) begin bad++; $display("FAIL sync_t2_ce got=%b exp=100", ce_s); end
        adv;
        total++;
        if (ce_s !== 3'b000) begin bad++; $display("FAIL sync_t3_ce got=%b exp=000", ce_s); end
        RESB = 1'b0;
        adv;
        total++;
        if (ce_s !== 3'b000) begin bad++; $display("FAIL midrun_reset_ce got=%b exp=000", ce_s); end
        RESB = 1'b1;
        f0 = -1; f2 = -1;
        for (int k = 0; k < 8; k++) begin
            adv;
            if (ce_s[0] && f0 < 0) f0 = k;
            if (ce_s[2] && f2 < 0) f2 = k;
        end
        total += 2;
        if (f0 != 3) begin bad++; $display("FAIL post_reset_ch0_first got=%0d exp=3", f0); end
        if (f2 != 6) begin bad++; $display("FAIL post_reset_ch2_first got=%0d exp=6", f2); end
    endtask

    initial begin
        RESB = 1'b0; RUN = 3'b000; SYNC = 1'b0; CFG_WE = 1'b0;
        CFG_CH = 2'd0; CFG_MUL = 9'd0; CFG_DIV = 9'd0;
        test_reset;
        test_rates;
        test_run_gap;
        test_cfg;
        test_degenerate;
        test_sync_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
